// File: rtl/dac_serial_tx.sv
// Serial driver for TLV5616-class DACs: {ctrl,data} words go out MSB-first on sclk/din/fs,
// and each word is steered to one of N_CH converters through its active-low chip select.
module dac_serial_tx #(
  parameter int unsigned CTRL_W  = 4,
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned N_CH    = 2,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 2,
  localparam int unsigned CHW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CHW-1:0]    in_ch,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              sclk,
  output logic              din,
  output logic              fs,
  output logic [N_CH-1:0]   cs_,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned W  = CTRL_W + DATA_W;
  localparam int unsigned HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BW = $clog2(W + 1);
  localparam int unsigned GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  localparam logic [HW-1:0] HLast = HW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HPre  = HW'((CLK_DIV > 1) ? CLK_DIV - 2 : 0);
  localparam logic [BW-1:0] BLast = BW'(W - 1);
  localparam logic [GW-1:0] GLast = GW'((CS_GAP > 0) ? CS_GAP - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t        state;
  logic [HW-1:0] hcnt;
  logic [BW-1:0] bcnt;
  logic [GW-1:0] gcnt;
  logic [W-1:0]  shreg;

  logic [W-1:0]    word;
  logic            ch_ok;
  logic [N_CH-1:0] cs_sel;

  always_comb begin
    word   = {in_ctrl, in_data};
    ch_ok  = (32'(in_ch) < N_CH);
    cs_sel = ~(N_CH'(1) << in_ch);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hcnt     <= '0;
      bcnt     <= '0;
      gcnt     <= '0;
      shreg    <= '0;
      sclk     <= 1'b1;
      din      <= 1'b0;
      fs       <= 1'b1;
      cs_      <= '1;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            if (ch_ok) begin
              state    <= SETUP;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              cs_      <= cs_sel;
              fs       <= 1'b0;
              din      <= word[W-1];
              shreg    <= word;
              hcnt     <= '0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (hcnt == HLast) begin
            state <= SHIFT;
            hcnt  <= '0;
            bcnt  <= '0;
            sclk  <= 1'b0;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        SHIFT: begin
          if (hcnt != HLast) begin
            hcnt <= hcnt + 1'b1;
          end else begin
            hcnt <= '0;
            if (!sclk) begin
              // Rising sclk: present the next bit so din is settled well before the next fall.
              sclk <= 1'b1;
              if (bcnt != BLast) begin
                din   <= shreg[W-2];
                shreg <= {shreg[W-2:0], 1'b0};
              end
            end else if (bcnt == BLast) begin
              state <= HOLD;
              done  <= (CLK_DIV == 1);
            end else begin
              bcnt <= bcnt + 1'b1;
              sclk <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (hcnt == HLast) begin
            hcnt <= '0;
            fs   <= 1'b1;
            cs_  <= '1;
            din  <= 1'b0;
            if (CS_GAP == 0) begin
              state    <= IDLE;
              busy     <= 1'b0;
              in_ready <= 1'b1;
            end else begin
              state <= GAP;
              gcnt  <= '0;
            end
          end else begin
            hcnt <= hcnt + 1'b1;
            // done occupies the final HOLD cycle, just before the frame closes.
            if (CLK_DIV > 1 && hcnt == HPre) done <= 1'b1;
          end
        end
        GAP: begin
          if (gcnt == GLast) begin
            state    <= IDLE;
            busy     <= 1'b0;
            in_ready <= 1'b1;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_serial_tx.sv
// Randomised self-checking bench for dac_serial_tx: a frame-level reference model derives the
// expected bit stream, chip-select pattern and frame timing from the word and parameters.
module tb_dac_serial_tx;

  localparam int W    = 16;
  localparam int CD0  = 2;
  localparam int GAP0 = 2;
  localparam int CD1  = 1;
  localparam int GAP1 = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v0, rdy0, sclk0, din0, fs0, busy0, done0, err0;
  logic [0:0]  ch0;
  logic [3:0]  ctl0;
  logic [11:0] dat0;
  logic [1:0]  cs0;

  logic        v1, rdy1, sclk1, din1, fs1, busy1, done1, err1;
  logic [1:0]  ch1;
  logic [3:0]  ctl1;
  logic [11:0] dat1;
  logic [2:0]  cs1;

  dac_serial_tx #(.CTRL_W(4), .DATA_W(12), .N_CH(2), .CLK_DIV(CD0), .CS_GAP(GAP0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0), .in_ch(ch0), .in_ctrl(ctl0),
    .in_data(dat0), .sclk(sclk0), .din(din0), .fs(fs0), .cs_(cs0), .busy(busy0),
    .done(done0), .err(err0)
  );

  dac_serial_tx #(.CTRL_W(4), .DATA_W(12), .N_CH(3), .CLK_DIV(CD1), .CS_GAP(GAP1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_ch(ch1), .in_ctrl(ctl1),
    .in_data(dat1), .sclk(sclk1), .din(din1), .fs(fs1), .cs_(cs1), .busy(busy1),
    .done(done1), .err(err1)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int overlap0 = 0;
  always @(negedge clk) if (!rst && $countones(~cs0) > 1) overlap0++;

  // One frame on dut0; with keep=1 in_valid stays high so the next call follows back-to-back.
  task automatic frame0(input int ch, input int ctl, input int dat, input bit keep);
    logic [15:0] word, got;
    logic [1:0]  exp_cs;
    int nbits, done_k, done_n, rdy_k, fs_low_n, cs_bad, busy_bad, t;
    logic psclk;
    word   = {ctl[3:0], dat[11:0]};
    exp_cs = 2'b11;
    exp_cs[ch] = 1'b0;
    t = 0;
    while (!rdy0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    ch0 = ch[0:0]; ctl0 = ctl[3:0]; dat0 = dat[11:0]; v0 = 1'b1;
    @(posedge clk);
    got = '0; nbits = 0; done_k = -1; done_n = 0; rdy_k = -1;
    fs_low_n = 0; cs_bad = 0; busy_bad = 0; psclk = 1'b1;
    for (int k = 0; k < 300 && rdy_k < 0; k++) begin
      @(negedge clk);
      if (k == 0 && !keep) v0 = 1'b0;
      if (k == 5) begin
        ch0 = ~ch0; ctl0 = ~ctl0; dat0 = ~dat0;
      end
      if (psclk && !sclk0) begin
        got = {got[14:0], din0};
        nbits++;
      end
      psclk = sclk0;
      if (done0) begin
        done_n++;
        done_k = k;
      end
      if (!fs0) begin
        fs_low_n++;
        if (cs0 !== exp_cs) cs_bad++;
      end else if (cs0 !== 2'b11) cs_bad++;
      if (rdy0) rdy_k = k;
      else if (!busy0) busy_bad++;
    end
    check("frame_bits", 32'(got), 32'(word));
    check("frame_nbits", nbits, W);
    check("done_cycle", done_k, CD0 * (2 * W + 2) - 1);
    check("done_width", done_n, 1);
    check("ready_cycle", rdy_k, CD0 * (2 * W + 2) + GAP0);
    check("fs_low_len", fs_low_n, CD0 * (2 * W + 2));
    check("cs_pattern", cs_bad, 0);
    check("busy_span", busy_bad, 0);
  endtask

  initial begin
    int err_n, err_k, act, t, nbits, done_k, rdy_k, cs_bad;
    logic [15:0] word, got;
    logic psclk;
    v0 = 0; ch0 = '0; ctl0 = '0; dat0 = '0;
    v1 = 0; ch1 = '0; ctl1 = '0; dat1 = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(rdy0), 0);
    check("rst_pins", 32'({sclk0, din0, fs0, cs0}), 32'(5'b10111));
    check("rst_flags", 32'({busy0, done0, err0}), 0);
    rst = 1'b0;
    #1 check("ready_before_edge", 32'(rdy0), 0);
    @(posedge clk);
    #1 check("ready_after_edge", 32'(rdy0), 1);

    frame0(0, 4'b0100, 12'hA5C, 1'b0);
    frame0(1, $urandom, 12'hFFF, 1'b0);
    frame0(0, $urandom, $urandom, 1'b1);
    frame0(1, $urandom, $urandom, 1'b0);
    for (int i = 0; i < 12; i++) begin
      frame0($urandom_range(0, 1), $urandom, $urandom, 1'($urandom_range(0, 1)));
      if (!v0) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    @(negedge clk);
    v0 = 1'b0;
    check("cs_overlap", overlap0, 0);

    // Abort a frame mid-shift with an asynchronous reset.
    t = 0;
    while (!rdy0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    ch0 = 1'b0; ctl0 = $urandom; dat0 = $urandom; v0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_pins", 32'({sclk0, fs0, cs0}), 32'(4'b1111));
    check("abort_busy", 32'(busy0), 0);
    check("abort_ready", 32'(rdy0), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 check("abort_ready_back", 32'(rdy0), 1);
    frame0(1, $urandom, $urandom, 1'b0);

    // Out-of-range channel on the three-converter instance.
    @(negedge clk);
    ch1 = 2'd3; ctl1 = $urandom; dat1 = $urandom; v1 = 1'b1;
    @(posedge clk);
    err_n = 0; err_k = -1; act = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) v1 = 1'b0;
      if (err1) begin
        err_n++;
        err_k = k;
      end
      if (!sclk1 || !fs1 || cs1 !== 3'b111 || busy1 || !rdy1) act++;
    end
    check("err_count", err_n, 1);
    check("err_cycle", err_k, 0);
    check("err_no_activity", act, 0);

    // A legal frame on channel 2 of the fast (sclk = clk/2, no gap) instance.
    word = 16'($urandom);
    ch1 = 2'd2; ctl1 = word[15:12]; dat1 = word[11:0]; v1 = 1'b1;
    @(posedge clk);
    got = '0; nbits = 0; done_k = -1; rdy_k = -1; cs_bad = 0; psclk = 1'b1;
    for (int k = 0; k < 100 && rdy_k < 0; k++) begin
      @(negedge clk);
      if (k == 0) v1 = 1'b0;
      if (psclk && !sclk1) begin
        got = {got[14:0], din1};
        nbits++;
      end
      psclk = sclk1;
      if (done1) done_k = k;
      if (!fs1 && cs1 !== 3'b011) cs_bad++;
      if (rdy1) rdy_k = k;
    end
    check("fast_bits", 32'(got), 32'(word));
    check("fast_nbits", nbits, W);
    check("fast_done", done_k, CD1 * (2 * W + 2) - 1);
    check("fast_ready", rdy_k, CD1 * (2 * W + 2) + GAP1);
    check("fast_cs", cs_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
